switch_debounce_pulse: RTL and testbench
========================================

// Module: switch_debounce_pulse
// PURPOSE
//  Conditions one raw board input (slide switch / push-button) into a clean level plus
//  single-cycle edge pulses, sampled on the 50 MHz board clock.
//  Sits directly upstream of the sequence-detector FSMs.
//  Its Level output (or Rise pulse) supplies their step clock/enable, replacing hand-toggled switch clocks.
//  Rejects contact bounce and metastability; never passes a glitch shorter than the stability window.
// PARAMETERS
//  SYNC_STAGES    2        synchronizer flop count (>=2)
//  STABLE_CYCLES  500000   consecutive agreeing samples after first sample to accept a change (10 ms @ 50 MHz); >=1
//  CNT_W          19       counter width; 2**CNT_W >= STABLE_CYCLES
// PORTS
//  Clock    in   1  board clock; all flops on posedge
//  Resetn   in   1  asynchronous, active-low reset
//  Enable   in   1  1 = run; 0 = freeze FSM and counter (synchronizer keeps running)
//  Button   in   1  raw, asynchronous, bouncing input
//  Level    out  1  debounced registered level
//  Rise     out  1  one-cycle pulse when Level goes 0->1
//  Fall     out  1  one-cycle pulse when Level goes 1->0
//  State    out  2  current FSM state, for LED debug
// BEHAVIOUR
//  Reset (Resetn=0, async): sync flops=0, state=S_LOW, count=0, Level=0, Rise=0, Fall=0.
//  s = output of SYNC_STAGES-deep flop chain on Button.
//  FSM (2-bit): S_LOW=00, S_CHK_HIGH=01, S_HIGH=10, S_CHK_LOW=11.
//   S_LOW:      s=1 -> S_CHK_HIGH, count<=0; else stay.
//   S_CHK_HIGH: s=0 -> S_LOW (glitch rejected, no pulse).
//               s=1 and count==STABLE_CYCLES-1 -> S_HIGH; Level<=1; Rise<=1.
//               s=1 otherwise -> count<=count+1.
//   S_HIGH:     s=0 -> S_CHK_LOW, count<=0; else stay.
//   S_CHK_LOW:  mirror of S_CHK_HIGH: s=1 -> S_HIGH.
//               s=0 at count==STABLE_CYCLES-1 -> S_LOW; Level<=0; Fall<=1.
//  Rise/Fall are registered; high for exactly one cycle, the same cycle Level first shows the new value.
//  Rise and Fall are never both 1.
//  Latency: Button change seen before edge k -> Level changes after edge k+SYNC_STAGES+STABLE_CYCLES.
//  Acceptance requires STABLE_CYCLES+1 consecutive equal samples of s.
//  A pulse of <=STABLE_CYCLES cycles on s is ignored entirely.
//  Enable=0: state, count and Level hold; Rise/Fall forced 0.
//  Enable=0 mid-check: count resumes from held value on re-enable; s is re-examined on that edge.
//  Counter never wraps: it is reset on every entry to a CHK state.
//  Counter is compared only up to STABLE_CYCLES-1.
//  Input toggling every cycle forever: FSM oscillates LOW<->CHK_HIGH; Level stays 0.
//  Reset asserted mid-check: immediate return to reset values; no pulse emitted.
// STRUCTURE
//  debounce_defs.vh: state encodings S_LOW/S_CHK_HIGH/S_HIGH/S_CHK_LOW, default timing constants.
//  Sub-module bit_synchronizer (#STAGES; Clock, Resetn, d, q): the flop chain.
//  Top: next-state logic (combinational case), state/count/output registers.
// TESTING  (bench overrides STABLE_CYCLES=4, SYNC_STAGES=2)
//  1 Reset: Resetn=0 with Button=1 -> Level=0, Rise=Fall=0, State=00;
//    release, Button held 1 -> Level=1 after 7 edges, Rise=1 for exactly that one cycle.
//  2 Glitch: Button high for 4 cycles from Level=0 -> Level stays 0, no Rise, State returns to 00.
//    Button high for 5 cycles -> Level=1.
//  3 Bounce: Button pattern 1,0,1,1,0,1 then steady 1 -> one Rise only.
//    Rise occurs 7 edges after the final 0->1 transition.
//  4 Release: from Level=1, Button 0 steady -> Fall one cycle, Level=0 after 7 edges, State 10->11->00.
//  5 Enable: drop Enable during S_CHK_HIGH at count=2 for 10 cycles -> State/count frozen, no Rise.
//    Re-enable -> Rise 2 edges later.
//  6 Async reset in S_CHK_LOW -> Level, State, pulses cleared before next Clock edge.

Source files
------------

// File: rtl/switch_debounce_pulse_pkg.sv
// ============================================================================
// Module  : switch_debounce_pulse_pkg
// Brief   : FSM state encodings and default timing constants for the debouncer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'b00,
        S_CHK_HIGH = 2'b01,
        S_HIGH     = 2'b10,
        S_CHK_LOW  = 2'b11
    } state_t;

    // 10 ms stability window at the 50 MHz board clock.
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 500000;
    localparam int DEF_CNT_W         = 19;

endpackage

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// ============================================================================
// Module  : bit_synchronizer
// Brief   : STAGES-deep flop chain bringing an asynchronous bit into Clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/switch_debounce_pulse.sv
// ============================================================================
// Module  : switch_debounce_pulse
// Brief   : Debounces a raw switch into a clean level plus one-cycle edge pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce_pulse
    import switch_debounce_pulse_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Enable,
    input  logic       Button,
    output logic       Level,
    output logic       Rise,
    output logic       Fall,
    output logic [1:0] State
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] count;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clock  (Clock),
        .Resetn (Resetn),
        .d      (Button),
        .q      (s)
    );

    // Pulses default low every cycle so they last exactly one cycle and
    // are forced off whenever Enable is low.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_LOW;
            count <= '0;
            Level <= 1'b0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
        end else begin
            Rise <= 1'b0;
            Fall <= 1'b0;
            if (Enable) begin
                case (state)
                    S_LOW: begin
                        if (s) begin
                            state <= S_CHK_HIGH;
                            count <= '0;
                        end
                    end
                    S_CHK_HIGH: begin
                        if (!s) begin
                            state <= S_LOW;
                        end else if (count == LAST_COUNT) begin
                            state <= S_HIGH;
                            Level <= 1'b1;
                            Rise  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (!s) begin
                            state <= S_CHK_LOW;
                            count <= '0;
                        end
                    end
                    S_CHK_LOW: begin
                        if (s) begin
                            state <= S_HIGH;
                        end else if (count == LAST_COUNT) begin
                            state <= S_LOW;
                            Level <= 1'b0;
                            Fall  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: state <= S_LOW;
                endcase
            end
        end
    end

    assign State = state;

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce_pulse.sv
// ============================================================================
// Module  : tb_switch_debounce_pulse
// Brief   : Directed bench; edge pulses are checked against a queue of expected events.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_debounce_pulse;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic       Enable = 1'b1;
    logic       Button = 1'b1;
    logic       Level;
    logic       Rise;
    logic       Fall;
    logic [1:0] State;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit is_rise;
        int at_cyc;
    } exp_t;

    exp_t exp_q[$];

    switch_debounce_pulse #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Enable (Enable),
        .Button (Button),
        .Level  (Level),
        .Rise   (Rise),
        .Fall   (Fall),
        .State  (State)
    );

    always #10 Clock = ~Clock;

    // Edges are numbered from 1; at a negedge cyc equals the latest edge.
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input bit is_rise, input int at_cyc);
        exp_t e;
        e.is_rise = is_rise;
        e.at_cyc  = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Monitor: every Rise/Fall must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        exp_t e;
        if (Rise && Fall) begin
            check("rise_and_fall_together", 1, 0);
        end
        if (Rise || Fall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_rise", int'(Rise), 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_is_rise", int'(Rise), int'(e.is_rise));
                check("pulse_cycle", cyc, e.at_cyc);
            end
        end
    end

    initial begin
        // 1: reset with Button high, then release.
        edges(3);
        check("reset_level", int'(Level), 0);
        check("reset_rise", int'(Rise), 0);
        check("reset_fall", int'(Fall), 0);
        check("reset_state", int'(State), 0);
        Resetn = 1'b1;
        expect_pulse(1'b1, cyc + 7);
        edges(6);
        check("rst_level_not_yet", int'(Level), 0);
        edges(2);
        check("rst_level_high", int'(Level), 1);
        check("rst_state_high", int'(State), 2);

        // 4: release, watch HIGH -> CHK_LOW -> LOW.
        Button = 1'b0;
        expect_pulse(1'b0, cyc + 7);
        edges(2);
        check("rel_state_high", int'(State), 2);
        edges(1);
        check("rel_state_chk_low", int'(State), 3);
        edges(3);
        check("rel_level_still_1", int'(Level), 1);
        edges(1);
        check("rel_state_low", int'(State), 0);
        check("rel_level_low", int'(Level), 0);

        // 2: 4-cycle glitch rejected, 5-cycle pulse accepted.
        edges(2);
        Button = 1'b1;
        edges(4);
        Button = 1'b0;
        edges(10);
        check("glitch_level", int'(Level), 0);
        check("glitch_state", int'(State), 0);
        Button = 1'b1;
        expect_pulse(1'b1, cyc + 7);
        edges(5);
        Button = 1'b0;
        expect_pulse(1'b0, cyc + 7);
        edges(2);
        check("pulse5_level_high", int'(Level), 1);
        edges(10);
        check("pulse5_level_back", int'(Level), 0);

        // 3: bounce 1,0,1,1,0,1 then steady 1 gives a single Rise.
        Button = 1'b1; edges(1);
        Button = 1'b0; edges(1);
        Button = 1'b1; edges(2);
        Button = 1'b0; edges(1);
        Button = 1'b1;
        expect_pulse(1'b1, cyc + 7);
        edges(6);
        check("bounce_level_not_yet", int'(Level), 0);
        edges(3);
        check("bounce_level_high", int'(Level), 1);

        // Back to LOW before the enable test.
        Button = 1'b0;
        expect_pulse(1'b0, cyc + 7);
        edges(10);
        check("pre_en_level", int'(Level), 0);

        // 5: freeze in CHK_HIGH at count 2.
        Button = 1'b1;
        edges(5);
        check("en_state_chk_high", int'(State), 1);
        Enable = 1'b0;
        edges(10);
        check("en_frozen_state", int'(State), 1);
        check("en_frozen_level", int'(Level), 0);
        Enable = 1'b1;
        expect_pulse(1'b1, cyc + 2);
        edges(1);
        check("en_resume_level_0", int'(Level), 0);
        edges(1);
        check("en_resume_level_1", int'(Level), 1);

        // 6: async reset during CHK_LOW.
        edges(2);
        Button = 1'b0;
        edges(4);
        check("ar_state_chk_low", int'(State), 3);
        #2;
        Resetn = 1'b0;
        #1;
        check("ar_level", int'(Level), 0);
        check("ar_state", int'(State), 0);
        check("ar_rise", int'(Rise), 0);
        check("ar_fall", int'(Fall), 0);
        edges(3);
        Resetn = 1'b1;
        edges(12);
        check("ar_after_level", int'(Level), 0);
        check("ar_after_state", int'(State), 0);

        check("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
